// File: rtl/irq_scheduler.sv
// Machine-mode interrupt scheduler: timer block, software interrupt bit and
// external line synchroniser, arbitrated into a single req/ack trap request.
`timescale 1ns/1ps

module irq_scheduler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic        mstatus_mie,
    input  logic [2:0]  mie,
    input  logic        bus_we,
    input  logic [2:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq_req,
    output logic [31:0] irq_cause,
    input  logic        irq_ack,
    input  logic        mret,
    output logic [2:0]  mip
);

    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

    localparam logic [31:0] CauseMei = 32'h8000_000B;
    localparam logic [31:0] CauseMsi = 32'h8000_0003;
    localparam logic [31:0] CauseMti = 32'h8000_0007;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        IN_TRAP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PsW-1:0] psCnt_q, psCnt_d;
    logic [63:0]    mtime_q, mtime_d;
    logic [63:0]    mtimecmp_q, mtimecmp_d;
    logic           msip_q, msip_d;
    logic           meipMeta_q, meipSync_q;
    logic           irqReq_q, irqReq_d;
    logic [31:0]    irqCause_q, irqCause_d;

    logic        wrMtimeLo, wrMtimeHi, wrCmpLo, wrCmpHi, wrMsip;
    logic        tick, mtip;
    logic [2:0]  enabled;
    logic [31:0] winCause;

    assign wrMtimeLo = bus_we && (bus_addr == 3'd0);
    assign wrMtimeHi = bus_we && (bus_addr == 3'd1);
    assign wrCmpLo   = bus_we && (bus_addr == 3'd2);
    assign wrCmpHi   = bus_we && (bus_addr == 3'd3);
    assign wrMsip    = bus_we && (bus_addr == 3'd4);
    assign tick      = (psCnt_q == PsLast);

    // A software write to either mtime half suppresses that cycle's increment
    // and restarts the prescaler so the new value lasts a full period.
    always_comb begin
        mtime_d = mtime_q;
        psCnt_d = psCnt_q;
        if (wrMtimeLo) begin
            mtime_d[31:0] = bus_wdata;
            psCnt_d       = '0;
        end else if (wrMtimeHi) begin
            mtime_d[63:32] = bus_wdata;
            psCnt_d        = '0;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
            psCnt_d = '0;
        end else begin
            psCnt_d = psCnt_q + PsW'(1);
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wrCmpLo) mtimecmp_d[31:0]  = bus_wdata;
        if (wrCmpHi) mtimecmp_d[63:32] = bus_wdata;
        if (wrMsip)  msip_d            = bus_wdata[0];
    end

    always_comb begin
        bus_rdata = 32'd0;
        case (bus_addr)
            3'd0:    bus_rdata = mtime_q[31:0];
            3'd1:    bus_rdata = mtime_q[63:32];
            3'd2:    bus_rdata = mtimecmp_q[31:0];
            3'd3:    bus_rdata = mtimecmp_q[63:32];
            3'd4:    bus_rdata = {31'd0, msip_q};
            default: bus_rdata = 32'd0;
        endcase
    end

    assign mtip    = (mtime_q >= mtimecmp_q);
    assign mip     = {meipSync_q, mtip, msip_q};
    assign enabled = mip & mie & {3{mstatus_mie}};

    always_comb begin
        winCause = CauseMti;
        if (enabled[2])      winCause = CauseMei;
        else if (enabled[0]) winCause = CauseMsi;
    end

    // Request and cause are frozen once raised; only ack moves us on.
    always_comb begin
        state_d    = state_q;
        irqReq_d   = irqReq_q;
        irqCause_d = irqCause_q;
        case (state_q)
            IDLE: begin
                if (|enabled) begin
                    state_d    = REQ;
                    irqReq_d   = 1'b1;
                    irqCause_d = winCause;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d  = IN_TRAP;
                    irqReq_d = 1'b0;
                end
            end
            IN_TRAP: begin
                if (mret) state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                irqReq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            psCnt_q    <= '0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q     <= 1'b0;
            meipMeta_q <= 1'b0;
            meipSync_q <= 1'b0;
            irqReq_q   <= 1'b0;
            irqCause_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            psCnt_q    <= psCnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            meipMeta_q <= ext_irq;
            meipSync_q <= meipMeta_q;
            irqReq_q   <= irqReq_d;
            irqCause_q <= irqCause_d;
        end
    end

    assign irq_req   = irqReq_q;
    assign irq_cause = irqCause_q;

endmodule

// File: tb/tb_irq_scheduler.sv
// Scoreboard bench for irq_scheduler: two instances (PRESCALE 1 and 3) share
// the stimulus and are compared every cycle against a behavioural model.
`timescale 1ns/1ps

module tb_irq_scheduler;

    localparam int PS_A = 1;
    localparam int PS_B = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        extIrq = 1'b0;
    logic        gmie = 1'b0;
    logic [2:0]  mieIn = 3'd0;
    logic        busWe = 1'b0;
    logic [2:0]  busAddr = 3'd0;
    logic [31:0] busWdata = 32'd0;
    logic        irqAck = 1'b0;
    logic        mretIn = 1'b0;

    logic [31:0] rdataA, causeA, rdataB, causeB;
    logic        reqA, reqB;
    logic [2:0]  mipA, mipB;

    irq_scheduler #(.PRESCALE(PS_A)) dutA (
        .clk(clk), .rst(rst), .ext_irq(extIrq), .mstatus_mie(gmie), .mie(mieIn),
        .bus_we(busWe), .bus_addr(busAddr), .bus_wdata(busWdata), .bus_rdata(rdataA),
        .irq_req(reqA), .irq_cause(causeA), .irq_ack(irqAck), .mret(mretIn), .mip(mipA)
    );

    irq_scheduler #(.PRESCALE(PS_B)) dutB (
        .clk(clk), .rst(rst), .ext_irq(extIrq), .mstatus_mie(gmie), .mie(mieIn),
        .bus_we(busWe), .bus_addr(busAddr), .bus_wdata(busWdata), .bus_rdata(rdataB),
        .irq_req(reqB), .irq_cause(causeB), .irq_ack(irqAck), .mret(mretIn), .mip(mipB)
    );

    always #5 clk = ~clk;

    // mtime is modelled as a base value plus elapsed edges divided by PRESCALE.
    typedef struct {
        logic [63:0] base;
        logic [63:0] cyc;
        logic [63:0] cmp;
        logic        msip;
        logic        s1;
        logic        s2;
        int          phase;
        logic        req;
        logic [31:0] cause;
    } model_t;

    typedef struct {
        logic        req;
        logic [31:0] cause;
        logic [2:0]  mip;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
    } pair_t;

    pair_t  expQ[$];
    model_t mA, mB;
    int     checks = 0;
    int     failures = 0;
    bit     started = 1'b0;

    function automatic model_t modelReset();
        model_t m;
        m.base = 64'd0; m.cyc = 64'd0; m.cmp = '1; m.msip = 1'b0;
        m.s1 = 1'b0; m.s2 = 1'b0; m.phase = 0; m.req = 1'b0; m.cause = 32'd0;
        return m;
    endfunction

    function automatic logic [63:0] timeOf(model_t m, int ps);
        return m.base + (m.cyc / 64'(ps));
    endfunction

    function automatic logic [2:0] pendOf(model_t m, int ps);
        return {m.s2, (timeOf(m, ps) >= m.cmp), m.msip};
    endfunction

    function automatic model_t modelStep(model_t m, int ps);
        model_t      n = m;
        logic [2:0]  en;
        logic [63:0] t;
        en = pendOf(m, ps) & mieIn & {3{gmie}};
        case (m.phase)
            0: if (en != 3'd0) begin
                n.phase = 1;
                n.req   = 1'b1;
                n.cause = en[2] ? 32'h8000_000B : (en[0] ? 32'h8000_0003 : 32'h8000_0007);
            end
            1: if (irqAck) begin
                n.phase = 2;
                n.req   = 1'b0;
            end
            default: if (mretIn) n.phase = 0;
        endcase
        t = timeOf(m, ps);
        if (busWe && busAddr == 3'd0) begin
            n.base = {t[63:32], busWdata};
            n.cyc  = 64'd0;
        end else if (busWe && busAddr == 3'd1) begin
            n.base = {busWdata, t[31:0]};
            n.cyc  = 64'd0;
        end else begin
            n.cyc = m.cyc + 64'd1;
        end
        if (busWe && busAddr == 3'd2) n.cmp[31:0]  = busWdata;
        if (busWe && busAddr == 3'd3) n.cmp[63:32] = busWdata;
        if (busWe && busAddr == 3'd4) n.msip       = busWdata[0];
        n.s1 = extIrq;
        n.s2 = m.s1;
        return n;
    endfunction

    function automatic exp_t expOf(model_t m, int ps, logic [2:0] addr);
        exp_t        e;
        logic [63:0] t;
        t       = timeOf(m, ps);
        e.req   = m.req;
        e.cause = m.cause;
        e.mip   = pendOf(m, ps);
        case (addr)
            3'd0:    e.rdata = t[31:0];
            3'd1:    e.rdata = t[63:32];
            3'd2:    e.rdata = m.cmp[31:0];
            3'd3:    e.rdata = m.cmp[63:32];
            3'd4:    e.rdata = {31'd0, m.msip};
            default: e.rdata = 32'd0;
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareSide(input string tag, input exp_t e, input logic req,
                               input logic [31:0] cause, input logic [2:0] mip,
                               input logic [31:0] rdata);
        checkOutput({tag, " irq_req"}, {31'd0, req}, {31'd0, e.req});
        checkOutput({tag, " irq_cause"}, cause, e.cause);
        checkOutput({tag, " mip"}, {29'd0, mip}, {29'd0, e.mip});
        checkOutput({tag, " bus_rdata"}, rdata, e.rdata);
    endtask

    // One clock edge: inputs are set at a falling edge, models advanced, and
    // the expected post-edge view queued for the monitor.
    task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                                 input logic ack, input logic mr);
        pair_t p;
        busWe = we; busAddr = addr; busWdata = wdata; irqAck = ack; mretIn = mr;
        mA = modelStep(mA, PS_A);
        mB = modelStep(mB, PS_B);
        p.a = expOf(mA, PS_A, addr);
        p.b = expOf(mB, PS_B, addr);
        expQ.push_back(p);
        started = 1'b1;
        @(negedge clk);
    endtask

    task automatic doReset();
        pair_t p;
        rst = 1'b1; busWe = 1'b0; irqAck = 1'b0; mretIn = 1'b0;
        mA = modelReset();
        mB = modelReset();
        #1;
        compareSide("A async-reset", expOf(mA, PS_A, busAddr), reqA, causeA, mipA, rdataA);
        compareSide("B async-reset", expOf(mB, PS_B, busAddr), reqB, causeB, mipB, rdataB);
        p.a = expOf(mA, PS_A, busAddr);
        p.b = expOf(mB, PS_B, busAddr);
        expQ.push_back(p);
        started = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n, input logic [2:0] addr);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, addr, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic busWrite(input logic [2:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, data, 1'b0, 1'b0);
    endtask

    task automatic ackOnce();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic mretOnce();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        pair_t p;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL scoreboard: got empty queue expected an entry at %0t", $time);
                end else begin
                    p = expQ.pop_front();
                    compareSide("A", p.a, reqA, causeA, mipA, rdataA);
                    compareSide("B", p.b, reqB, causeB, mipB, rdataB);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        @(negedge clk);
        doReset();

        // Timer path: mtimecmp = 20, only MTIE enabled.
        gmie = 1'b1; mieIn = 3'b010;
        busWrite(3'd2, 32'd20);
        busWrite(3'd3, 32'd0);
        idle(25, 3'd0);
        ackOnce();
        idle(2, 3'd0);
        mretOnce();
        busWrite(3'd3, 32'hFFFF_FFFF);
        ackOnce();
        mretOnce();
        idle(2, 3'd2);

        // Priority: external line and msip raised together.
        mieIn = 3'b111; extIrq = 1'b1;
        busWrite(3'd4, 32'd1);
        idle(3, 3'd4);
        ackOnce();
        mretOnce();
        idle(2, 3'd4);
        extIrq = 1'b0;
        busWrite(3'd4, 32'd0);
        ackOnce();
        idle(3, 3'd4);
        mretOnce();
        idle(3, 3'd4);

        // Masking by mstatus.MIE.
        gmie = 1'b0; extIrq = 1'b1;
        idle(12, 3'd5);
        gmie = 1'b1;
        idle(2, 3'd5);
        ackOnce();
        extIrq = 1'b0;
        idle(3, 3'd6);
        mretOnce();
        idle(2, 3'd7);

        // Request held after source drops; new source ignored inside the trap.
        extIrq = 1'b1;
        idle(4, 3'd4);
        extIrq = 1'b0;
        idle(5, 3'd4);
        ackOnce();
        busWrite(3'd4, 32'd1);
        idle(4, 3'd4);
        mretOnce();
        idle(2, 3'd4);
        ackOnce();
        busWrite(3'd4, 32'd0);
        mretOnce();
        idle(2, 3'd4);

        // Carry, write-over-increment and 64-bit wrap.
        mieIn = 3'b000;
        busWrite(3'd1, 32'd0);
        busWrite(3'd0, 32'hFFFF_FFFF);
        idle(1, 3'd0);
        idle(3, 3'd1);
        busWrite(3'd0, 32'h1234_5678);
        idle(2, 3'd0);
        busWrite(3'd0, 32'hFFFF_FFFF);
        busWrite(3'd1, 32'hFFFF_FFFF);
        idle(1, 3'd0);
        idle(1, 3'd1);
        idle(3, 3'd0);

        // Reset while a request is outstanding.
        mieIn = 3'b001;
        busWrite(3'd4, 32'd1);
        idle(2, 3'd4);
        doReset();
        idle(1, 3'd2);
        idle(1, 3'd3);

        // Randomised traffic.
        gmie = 1'b1; mieIn = 3'b111;
        for (int i = 0; i < 4000; i++) begin
            logic        we;
            logic [2:0]  addr;
            logic [31:0] wdata;
            if ($urandom_range(0, 399) == 0) begin
                doReset();
                continue;
            end
            if ($urandom_range(0, 15) == 0) extIrq = ~extIrq;
            if ($urandom_range(0, 31) == 0) mieIn = 3'($urandom);
            if ($urandom_range(0, 31) == 0) gmie = ($urandom_range(0, 3) != 0);
            we    = ($urandom_range(0, 4) == 0);
            addr  = 3'($urandom);
            wdata = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            applyStimulus(we, addr, wdata, ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
        end
        idle(2, 3'd0);

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
